// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter that shares four 1RW1R SRAM macros between a Wishbone slave
// and an auxiliary port B; one access at a time, port 0 writes only, port 1 reads only.
module sram_bank_arbiter #(
   parameter int NBANKS = 4,
   parameter int AW     = 8
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_we_i,
   input  logic [3:0]            wbs_sel_i,
   input  logic [31:0]           wbs_adr_i,
   input  logic [31:0]           wbs_dat_i,
   output logic                  wbs_ack_o,
   output logic [31:0]           wbs_dat_o,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [9:0]            b_addr,
   input  logic [31:0]           b_wdata,
   input  logic [3:0]            b_wmask,
   output logic                  b_ack,
   output logic [31:0]           b_rdata,
   output logic [NBANKS-1:0]     sram_csb0,
   output logic                  sram_web0,
   output logic [3:0]            sram_wmask0,
   output logic [AW-1:0]         sram_addr0,
   output logic [31:0]           sram_din0,
   output logic [NBANKS-1:0]     sram_csb1,
   output logic [AW-1:0]         sram_addr1,
   input  logic [32*NBANKS-1:0]  sram_dout1,
   output logic [1:0]            dbg_state
);

   // Handshake: port A request is cyc&stb, port B request is b_req held until b_ack.
   // The owner's ack is a single-cycle pulse in DONE; read data is registered and held.
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   state_t              state;
   logic                last_b;
   logic                owner_b;
   logic                we_q;
   logic [1:0]          bank_q;
   logic [AW-1:0]       addr_q;
   logic [3:0]          mask_q;
   logic [31:0]         din_q;
   logic [31:0]         rdata_q;
   logic [NBANKS-1:0]   csb0_q;
   logic [NBANKS-1:0]   csb1_q;

   logic                req_a;
   logic                grant_b;
   logic                sel_we;
   logic [1:0]          sel_bank;
   logic [AW-1:0]       sel_word;
   logic [3:0]          sel_mask;
   logic [31:0]         sel_wdata;
   logic [NBANKS-1:0]   sel_onehot;
   logic                unused_adr;

   assign req_a      = wbs_cyc_i & wbs_stb_i;
   // B wins when alone, or on a tie when A was the previous owner.
   assign grant_b    = b_req & (~req_a | ~last_b);
   assign unused_adr = ^{wbs_adr_i[31:12], wbs_adr_i[1:0]};

   always_comb begin
      sel_we    = wbs_we_i;
      sel_bank  = wbs_adr_i[11:10];
      sel_word  = wbs_adr_i[9:2];
      sel_mask  = wbs_sel_i;
      sel_wdata = wbs_dat_i;
      if (grant_b) begin
         sel_we    = b_we;
         sel_bank  = b_addr[9:8];
         sel_word  = b_addr[7:0];
         sel_mask  = b_wmask;
         sel_wdata = b_wdata;
      end
      sel_onehot = NBANKS'(1) << sel_bank;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state   <= IDLE;
         last_b  <= 1'b1;
         owner_b <= 1'b0;
         we_q    <= 1'b0;
         bank_q  <= '0;
         addr_q  <= '0;
         mask_q  <= '0;
         din_q   <= '0;
         rdata_q <= '0;
         csb0_q  <= '1;
         csb1_q  <= '1;
      end else begin
         case (state)
            IDLE: begin
               if (req_a | b_req) begin
                  owner_b <= grant_b;
                  last_b  <= grant_b;
                  we_q    <= sel_we;
                  bank_q  <= sel_bank;
                  addr_q  <= sel_word;
                  mask_q  <= sel_mask;
                  din_q   <= sel_wdata;
                  if (sel_we) csb0_q <= ~sel_onehot;
                  else        csb1_q <= ~sel_onehot;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               csb0_q <= '1;
               csb1_q <= '1;
               state  <= we_q ? DONE : WAIT;
            end
            WAIT: begin
               rdata_q <= sram_dout1[{bank_q, 5'd0} +: 32];
               state   <= DONE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // A master that abandons the cycle still lets the macro access finish, but gets no ack.
   assign wbs_ack_o   = (state == DONE) & ~owner_b & req_a;
   assign b_ack       = (state == DONE) & owner_b;
   assign wbs_dat_o   = rdata_q;
   assign b_rdata     = rdata_q;
   assign sram_csb0   = csb0_q;
   assign sram_csb1   = csb1_q;
   assign sram_web0   = 1'b0;
   assign sram_wmask0 = mask_q;
   assign sram_addr0  = addr_q;
   assign sram_addr1  = addr_q;
   assign sram_din0   = din_q;
   assign dbg_state   = state;

endmodule
